// File: rtl/pwm_duty_ctrl_if.sv
// ---------------------------------------------------------------------------
// pwm_duty_ctrl_if
// Signal bundle between the board buttons / PWM generator and the duty
// controller.
//
//   btn_increase  raw asynchronous increase button, active high
//   btn_decrease  raw asynchronous decrease button, active high
//   period_end    one-cycle pulse on the last cycle of each PWM period
//   duty_target   requested duty, moves immediately on each step
//   duty_active   duty driven to the PWM generator, moves only at period_end
//   duty_update   one-cycle pulse in the cycle after duty_active changed
//   at_max        duty_target is at full scale
//   at_min        duty_target is zero
//
// master: the environment (buttons + PWM generator) side
// slave : the duty controller side
// ---------------------------------------------------------------------------
interface pwm_duty_ctrl_if #(
    parameter int DUTY_W = 4
);
    logic              btn_increase;
    logic              btn_decrease;
    logic              period_end;
    logic [DUTY_W-1:0] duty_target;
    logic [DUTY_W-1:0] duty_active;
    logic              duty_update;
    logic              at_max;
    logic              at_min;

    modport master (
        output btn_increase,
        output btn_decrease,
        output period_end,
        input  duty_target,
        input  duty_active,
        input  duty_update,
        input  at_max,
        input  at_min
    );

    modport slave (
        input  btn_increase,
        input  btn_decrease,
        input  period_end,
        output duty_target,
        output duty_active,
        output duty_update,
        output at_max,
        output at_min
    );
endinterface

// File: rtl/pwm_duty_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_duty_ctrl
// Turns the increase/decrease push-buttons into saturating duty steps for the
// PWM generator. Buttons are synchronised, debounced, and a long hold turns
// into auto-repeat. The requested duty is handed to the generator only at a
// period boundary so a period is never cut short or stretched.
//
// Ports:
//   clk   system clock, everything on the rising edge
//   rst   synchronous active-high reset
//   bus   pwm_duty_ctrl_if.slave (buttons, period_end, duty outputs, flags)
//
// Button FSM:
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   IDLE        | no valid command; waiting for a single button
//   DEBOUNCE    | command captured, must stay stable before the first step
//   HOLD        | first step issued, waiting out the repeat delay
//   REPEAT      | auto-repeat, one step every REPEAT_RATE cycles
// ---------------------------------------------------------------------------
module pwm_duty_ctrl #(
    parameter int DUTY_STEPS      = 10,
    parameter int DUTY_W          = 4,
    parameter int INIT_DUTY       = 5,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_RATE     = 8
) (
    input  logic          clk,
    input  logic          rst,
    pwm_duty_ctrl_if.slave bus
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam logic [1:0] CMD_NONE = 2'd0;
    localparam logic [1:0] CMD_INC  = 2'd1;
    localparam logic [1:0] CMD_DEC  = 2'd2;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;
    localparam logic [1:0] ST_REPEAT   = 2'd3;

    localparam int CNT_MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int CNT_MAX   = (CNT_MAX_A > REPEAT_RATE) ? CNT_MAX_A : REPEAT_RATE;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST   = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    localparam logic [DUTY_W-1:0] DUTY_MAX   = DUTY_W'(DUTY_STEPS);
    localparam logic [DUTY_W-1:0] DUTY_INIT  = DUTY_W'(INIT_DUTY);
    localparam logic [DUTY_W-1:0] DUTY_ONE   = DUTY_W'(1);

    // -----------------------------------------------------------------------
    // Button synchronisers (bit 1 is the synchronised level)
    // -----------------------------------------------------------------------
    logic [1:0] sync_inc;
    logic [1:0] sync_dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_inc <= 2'b00;
            sync_dec <= 2'b00;
        end else begin
            sync_inc <= {sync_inc[0], bus.btn_increase};
            sync_dec <= {sync_dec[0], bus.btn_decrease};
        end
    end

    // Both buttons together decode to no command, so a two-finger press
    // never moves the duty.
    logic [1:0] cmd;

    always_comb begin
        cmd = CMD_NONE;
        if (sync_inc[1] && !sync_dec[1]) begin
            cmd = CMD_INC;
        end else if (sync_dec[1] && !sync_inc[1]) begin
            cmd = CMD_DEC;
        end
    end

    // -----------------------------------------------------------------------
    // Debounce / hold / repeat FSM
    // -----------------------------------------------------------------------
    logic [1:0]       state, state_nxt;
    logic [1:0]       cap, cap_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             step;

    always_comb begin
        state_nxt = state;
        cap_nxt   = cap;
        cnt_nxt   = cnt;
        step      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cmd != CMD_NONE) begin
                    state_nxt = ST_DEBOUNCE;
                    cap_nxt   = cmd;
                    cnt_nxt   = '0;
                end
            end

            ST_DEBOUNCE: begin
                // Any change, including a release or the other button joining
                // in, abandons the press without a step.
                if (cmd != cap) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    step      = 1'b1;
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end

            ST_HOLD: begin
                if (cmd != cap) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DELAY_LAST) begin
                    step      = 1'b1;
                    state_nxt = ST_REPEAT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end

            ST_REPEAT: begin
                // Exit takes priority over a step due in the same cycle.
                if (cmd != cap) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == RATE_LAST) begin
                    step      = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                cap_nxt   = CMD_NONE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cap   <= CMD_NONE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cap   <= cap_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Duty target (saturating) and period-aligned apply path
    // -----------------------------------------------------------------------
    logic [DUTY_W-1:0] duty_target_q, duty_target_nxt;
    logic [DUTY_W-1:0] duty_active_q;
    logic              duty_update_q;
    logic              load;

    always_comb begin
        duty_target_nxt = duty_target_q;
        if (step) begin
            if ((cap == CMD_INC) && (duty_target_q < DUTY_MAX)) begin
                duty_target_nxt = duty_target_q + DUTY_ONE;
            end else if ((cap == CMD_DEC) && (duty_target_q != '0)) begin
                duty_target_nxt = duty_target_q - DUTY_ONE;
            end
        end
    end

    // Uses the registered target, so a step landing on period_end is picked
    // up at the following boundary rather than mid-flight.
    assign load = bus.period_end && (duty_target_q != duty_active_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_target_q <= DUTY_INIT;
            duty_active_q <= DUTY_INIT;
            duty_update_q <= 1'b0;
        end else begin
            duty_target_q <= duty_target_nxt;
            if (load) begin
                duty_active_q <= duty_target_q;
            end
            duty_update_q <= load;
        end
    end

    assign bus.duty_target = duty_target_q;
    assign bus.duty_active = duty_active_q;
    assign bus.duty_update = duty_update_q;
    assign bus.at_max      = (duty_target_q == DUTY_MAX);
    assign bus.at_min      = (duty_target_q == '0);

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pwm_duty_ctrl
// Self-checking bench for pwm_duty_ctrl. A timing model driven from the raw
// button levels predicts duty_target/duty_active every cycle; every expected
// load is queued when period_end is driven and popped when duty_update shows.
// A table of press scenarios carries hand-derived end values, and two short
// hand-written sequences cover reset mid-hold and a step on period_end.
// ---------------------------------------------------------------------------
module tb_pwm_duty_ctrl;

    localparam int DUTY_STEPS      = 10;
    localparam int DUTY_W          = 4;
    localparam int INIT_DUTY       = 5;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int REPEAT_DELAY    = 16;
    localparam int REPEAT_RATE     = 8;

    // Steps fall on these counts of consecutive synchronised-command cycles.
    localparam int RUN_FIRST  = DEBOUNCE_CYCLES + 1;
    localparam int RUN_SECOND = RUN_FIRST + REPEAT_DELAY;
    localparam int RUN_THIRD  = RUN_SECOND + REPEAT_RATE;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pwm_duty_ctrl_if #(.DUTY_W(DUTY_W)) bif ();

    pwm_duty_ctrl #(
        .DUTY_STEPS      (DUTY_STEPS),
        .DUTY_W          (DUTY_W),
        .INIT_DUTY       (INIT_DUTY),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Model state and scoreboard
    // -----------------------------------------------------------------------
    int         m_tgt;
    int         m_act;
    int         m_run;
    logic       m_upd;
    logic [1:0] m_d1, m_d2, m_d2_prev;
    int         cyc = 0;
    logic [DUTY_W-1:0] sb_q[$];

    always @(negedge clk) begin
        if (bif.duty_update === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_update got duty_active %0d expected no pulse", bif.duty_active);
            end else begin
                check("update_value", 8'(bif.duty_active), 8'(sb_q.pop_front()));
            end
        end
    end

    // One clock cycle: drive inputs, advance the model, observe after the edge.
    task automatic drive(input logic inc, input logic dec, input logic pe, input logic r);
        logic [1:0] raw;
        int         cur_run;
        logic       stepping;
        rst              = r;
        bif.btn_increase = inc;
        bif.btn_decrease = dec;
        bif.period_end   = pe;
        raw = (inc && !dec) ? 2'd1 : ((dec && !inc) ? 2'd2 : 2'd0);
        if (r) begin
            m_tgt     = INIT_DUTY;
            m_act     = INIT_DUTY;
            m_upd     = 1'b0;
            m_run     = 0;
            m_d1      = 2'd0;
            m_d2      = 2'd0;
            m_d2_prev = 2'd0;
        end else begin
            if (m_d2 == 2'd0)           cur_run = 0;
            else if (m_d2 == m_d2_prev) cur_run = m_run + 1;
            else                        cur_run = 1;
            stepping = (cur_run == RUN_FIRST) || (cur_run == RUN_SECOND) ||
                       ((cur_run >= RUN_THIRD) && (((cur_run - RUN_THIRD) % REPEAT_RATE) == 0));
            m_upd = pe && (m_tgt != m_act);
            if (m_upd) begin
                sb_q.push_back(DUTY_W'(m_tgt));
                m_act = m_tgt;
            end
            if (stepping) begin
                if (m_d2 == 2'd1 && m_tgt < DUTY_STEPS) m_tgt = m_tgt + 1;
                else if (m_d2 == 2'd2 && m_tgt > 0)     m_tgt = m_tgt - 1;
            end
            m_d2_prev = m_d2;
            m_d2      = m_d1;
            m_d1      = raw;
            m_run     = cur_run;
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
        check("cyc_target", 8'(bif.duty_target), 8'(m_tgt));
        check("cyc_active", 8'(bif.duty_active), 8'(m_act));
        check("cyc_update", 8'(bif.duty_update), 8'(m_upd));
        check("cyc_at_max", 8'(bif.at_max), 8'(m_tgt == DUTY_STEPS));
        check("cyc_at_min", 8'(bif.at_min), 8'(m_tgt == 0));
    endtask

    // n cycles with a fixed button pattern and period_end every 20 cycles.
    task automatic run(input logic inc, input logic dec, input int n);
        for (int i = 0; i < n; i++) begin
            drive(inc, dec, (cyc % 20) == 19, 1'b0);
        end
    endtask

    typedef struct {
        string name;
        logic  do_reset;
        logic  inc;
        logic  dec;
        int    hold;
        int    gap;
        int    exp_tgt;
        logic  exp_max;
        logic  exp_min;
    } vec_t;

    vec_t vecs[8];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"inc_pulse_a", 1'b0, 1'b1, 1'b0, 10, 10,  6, 1'b0, 1'b0};
        vecs[1] = '{"inc_pulse_b", 1'b0, 1'b1, 1'b0, 10, 10,  7, 1'b0, 1'b0};
        vecs[2] = '{"inc_pulse_c", 1'b0, 1'b1, 1'b0, 10, 10,  8, 1'b0, 1'b0};
        vecs[3] = '{"inc_hold60",  1'b1, 1'b1, 1'b0, 60, 10, 10, 1'b1, 1'b0};
        vecs[4] = '{"dec_glitch",  1'b0, 1'b0, 1'b1,  3, 10, 10, 1'b1, 1'b0};
        vecs[5] = '{"both_held",   1'b0, 1'b1, 1'b1, 20, 10, 10, 1'b1, 1'b0};
        vecs[6] = '{"dec_hold79",  1'b0, 1'b0, 1'b1, 79, 10,  1, 1'b0, 1'b0};
        vecs[7] = '{"dec_from1",   1'b0, 1'b0, 1'b1, 40, 10,  0, 1'b0, 1'b1};

        rst              = 1'b1;
        bif.btn_increase = 1'b0;
        bif.btn_decrease = 1'b0;
        bif.period_end   = 1'b0;

        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_target", 8'(bif.duty_target), 8'd5);
        check("reset_active", 8'(bif.duty_active), 8'd5);
        check("reset_update", 8'(bif.duty_update), 8'd0);
        check("reset_at_max", 8'(bif.at_max), 8'd0);
        check("reset_at_min", 8'(bif.at_min), 8'd0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].do_reset) begin
                drive(1'b0, 1'b0, 1'b0, 1'b1);
                drive(1'b0, 1'b0, 1'b0, 1'b1);
            end
            run(vecs[i].inc, vecs[i].dec, vecs[i].hold);
            run(1'b0, 1'b0, vecs[i].gap);
            check({vecs[i].name, "_target"}, 8'(bif.duty_target), 8'(vecs[i].exp_tgt));
            check({vecs[i].name, "_at_max"}, 8'(bif.at_max), 8'(vecs[i].exp_max));
            check({vecs[i].name, "_at_min"}, 8'(bif.at_min), 8'(vecs[i].exp_min));
        end

        // Reset in the middle of a dec hold: back to 5, then a full debounce.
        run(1'b0, 1'b1, 10);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        run(1'b0, 1'b1, 6);
        check("rst_hold_no_early_step", 8'(bif.duty_target), 8'd5);
        run(1'b0, 1'b1, 1);
        check("rst_hold_first_step", 8'(bif.duty_target), 8'd4);
        run(1'b0, 1'b0, 10);

        // Step landing on period_end: the pre-step value is loaded, the new
        // one waits for the next boundary.
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("pending_target", 8'(bif.duty_target), 8'd6);
        check("pending_active", 8'(bif.duty_active), 8'd5);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, (i == 6), 1'b0);
            if (i == 6) begin
                check("coincide_active", 8'(bif.duty_active), 8'd6);
                check("coincide_target", 8'(bif.duty_target), 8'd7);
                check("coincide_update", 8'(bif.duty_update), 8'd1);
            end
        end
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("next_pe_active", 8'(bif.duty_active), 8'd7);
        check("next_pe_update", 8'(bif.duty_update), 8'd1);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("update_one_cycle", 8'(bif.duty_update), 8'd0);
        check("scoreboard_drained", 8'(sb_q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ctrl.md
Name: pwm_duty_ctrl

Overview:
Duty-cycle controller for the team's PWM generator. Synchronises and debounces the increase/decrease push-buttons, turns each press (and long hold) into 10% duty steps with saturation, and loads the new duty into the generator only at PWM period boundaries so no glitched period is produced. Sits between the board buttons and the PWM generator's duty input.

Parameters:
DUTY_STEPS, 10, number of duty steps; duty range is 0..DUTY_STEPS (10 = 100%)
DUTY_W, 4, width of duty values; must hold DUTY_STEPS
INIT_DUTY, 5, duty_target/duty_active value after reset (50%)
DEBOUNCE_CYCLES, 4, cycles a command must be stable before the first step
REPEAT_DELAY, 16, cycles of continued hold after the first step before auto-repeat starts
REPEAT_RATE, 8, cycles between auto-repeat steps

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
btn_increase  in  1  raw asynchronous increase button, active high
btn_decrease  in  1  raw asynchronous decrease button, active high
period_end  in  1  one-cycle pulse from PWM generator on the last cycle of each period
duty_target  out  DUTY_W  requested duty, updated immediately on each step
duty_active  out  DUTY_W  duty driven to the PWM generator, changes only at period_end
duty_update  out  1  one-cycle pulse, cycle after duty_active changes
at_max  out  1  duty_target == DUTY_STEPS
at_min  out  1  duty_target == 0

Behaviour:
- Reset (rst=1 at a clk edge): duty_target = duty_active = INIT_DUTY, duty_update = 0, FSM = IDLE, counters = 0, synchronisers = 0. Reset mid-press discards the press; a button still held after reset is handled as a new press (full debounce).
- Each button passes through a 2-flop synchroniser (2-cycle latency). Decoded command cmd: INC if only inc high, DEC if only dec high, NONE otherwise. Both pressed = NONE (no step).
- FSM with states IDLE, DEBOUNCE, HOLD, REPEAT, a captured command cap, and one cycle counter cnt:
  IDLE: cmd != NONE -> DEBOUNCE, cap = cmd, cnt = 0.
  DEBOUNCE: cmd != cap -> IDLE. Otherwise cnt++; when cnt reaches DEBOUNCE_CYCLES-1: issue one step, -> HOLD, cnt = 0.
  HOLD: cmd != cap -> IDLE. When cnt reaches REPEAT_DELAY-1: step, -> REPEAT, cnt = 0.
  REPEAT: cmd != cap -> IDLE. Step every REPEAT_RATE cycles (cnt wraps at REPEAT_RATE-1).
- Leaving HOLD/REPEAT goes to IDLE; a different command needs a fresh debounce. Release or glitch during DEBOUNCE produces no step.
- First step occurs 2 + DEBOUNCE_CYCLES cycles after the raw button rises; duty_target updates the cycle after the step.
- Step: INC -> duty_target+1 saturating at DUTY_STEPS; DEC -> duty_target-1 saturating at 0. No wrap-around, ever.
- Apply path: when period_end=1 and duty_target != duty_active, duty_active <= duty_target and duty_update pulses on the next cycle. A step coinciding with period_end: duty_active takes the pre-step duty_target; the new value is loaded at the next period_end. Multiple steps within one period collapse to one load of the latest value.
- at_max/at_min are combinational from duty_target.

Test Plan:
- Reset with defaults -> duty_target=duty_active=5, duty_update=0, at_max=at_min=0, FSM IDLE.
- Three inc pulses of 10 cycles each, 10-cycle gaps, period_end every 20 cycles -> duty_target 5->6->7->8, exactly one step per pulse, no repeat; duty_active follows only on period_end, each change followed by one duty_update pulse.
- Inc held 60 cycles from duty 5 -> steps at cycles 6, 22, 30, 38, 46, 54 relative to the press; duty_target reaches 10, stays 10, at_max=1.
- Dec glitch of 3 cycles; then both buttons held 20 cycles -> no step, duty_target unchanged.
- Dec held from duty 1 -> one step to 0, at_min=1, further repeat steps keep 0; rst asserted mid-hold -> returns to 5, next step requires full debounce.
- Step landing in the same cycle as period_end -> duty_active keeps the old value, loads the new one at the following period_end with one duty_update pulse.
